wb_arbiter_2m: RTL and testbench
================================

Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone (pipelined) arbiter.
- Shares a single peripheral bus segment (LED bar, UART, timer slaves behind the address decoder) between the CPU data port (m0) and a second requester such as a debug or DMA port (m1).
- Grants the bus for a whole CYC period with round-robin fairness.
- Routes ACK, read data and STALL back to the owning master only.

Parameters:
ADDR_WIDTH, 32, address bus width.
DATA_WIDTH, 32, data bus width.
TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with ARB_TIMEOUT_EN; must be >= 1 and < 2^16).

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst_n  in  1  reset, synchronous, active-low
i_m0_cyc / i_m1_cyc  in  1  master cycle request
i_m0_stb / i_m1_stb  in  1  master strobe
i_m0_we / i_m1_we  in  1  master write enable
i_m0_addr / i_m1_addr  in  ADDR_WIDTH  master address
i_m0_data / i_m1_data  in  DATA_WIDTH  master write data
o_m0_data / o_m1_data  out  DATA_WIDTH  read data to master
o_m0_ack / o_m1_ack  out  1  acknowledge to master
o_m0_stall / o_m1_stall  out  1  stall to master
o_s_cyc, o_s_stb, o_s_we  out  1  slave-side control
o_s_addr  out  ADDR_WIDTH  slave address
o_s_data  out  DATA_WIDTH  slave write data
i_s_data  in  DATA_WIDTH  slave read data
i_s_ack  in  1  slave acknowledge
i_s_stall  in  1  slave stall
o_grant  out  2  one-hot owner: bit0 = m0, bit1 = m1, 00 = idle

Behaviour:
- FSM states: IDLE, GNT0, GNT1 (plus DRAIN with the optional feature). State register and last_owner register (reset = 1, so m0 wins the first tie).
- Reset (i_rst_n low at a rising edge): state = IDLE, last_owner = 1, any outstanding transaction abandoned.
  - Combinational outputs follow the reset state: o_grant = 00, o_s_cyc = o_s_stb = o_s_we = 0, o_s_addr = o_s_data = 0.
  - o_m*_ack = 0, o_m*_data = 0, o_m*_stall = 1.
- IDLE:
  - Only i_mX_cyc high: go to GNTX next edge.
  - Both high: grant the master != last_owner.
  - Neither: stay.
  - Grant latency is 1 cycle from CYC assertion. No slave signal is driven in IDLE.
- GNTX:
  - o_s_cyc = i_mX_cyc, o_s_stb = i_mX_stb; we/addr/data muxed combinationally from mX.
  - o_mX_ack = i_s_ack, o_mX_data = i_s_data, o_mX_stall = i_s_stall.
  - Non-owner sees ack = 0, stall = 1, data = 0.
  - Owner keeps the bus while i_mX_cyc is high, regardless of the other request (multi-beat bursts are not interrupted).
- Release: at the edge where i_mX_cyc is low, last_owner <= X.
  - If the other master's cyc is high, go directly to its GNT state (no idle bubble).
  - Otherwise go to IDLE.
- ACKs are routed only while in GNTX. A slave ACK arriving in IDLE or DRAIN is dropped.
- Arbiter adds no registers in the data path: zero added latency once granted.
- Masters must hold CYC until all of their ACKs have returned (Wishbone rule).

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Enabled:
  - Adds outputs o_m0_err / o_m1_err (1 bit) and a 16-bit watchdog counter.
  - Counter clears on grant and on every i_s_ack; increments each cycle in GNTX while i_s_ack is low.
  - When counter == TIMEOUT_CYCLES - 1 and there is no ack that cycle:
    - Next cycle, o_mX_err pulses high for exactly one cycle.
    - FSM enters DRAIN: o_s_cyc = o_s_stb = 0, owner stall = 1.
    - FSM stays in DRAIN until i_mX_cyc is low, then follows the release rule.
  - Reset clears the counter; err outputs reset to 0.
- Disabled: no err ports, no counter; an unresponsive slave holds the grant indefinitely. TIMEOUT_CYCLES is ignored.

Test Plan:
- m0 only: cyc/stb/we = 1, addr = 0x10, data = 0xA5A5 -> o_grant = 01 one cycle later; o_s_* mirrors m0; slave ack routed to o_m0_ack only; o_m1_ack stays 0.
- Both masters raise cyc in the same cycle after reset -> m0 granted first.
  - m0 drops cyc -> o_grant = 10 at the next edge with no IDLE cycle.
  - Repeat the simultaneous request -> m1 is not favoured twice; m0 is granted.
- m0 issues a 4-beat read burst (reads 0x1,0x2,0x3,0x4) while m1 requests -> m1 stall = 1 throughout; grant passes to m1 only after m0 drops cyc.
- Slave stall: i_s_stall = 1 for 3 cycles during an m1 write -> o_m1_stall = 1 for exactly those cycles; o_s_stb held; one ack on completion.
- Reset mid-transaction: i_rst_n low for 1 cycle while GNT1 with stb high -> next cycle o_grant = 00, o_s_cyc = 0, all acks 0; first tie after reset goes to m0.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 4: slave never acks m0 -> o_m0_err pulses 1 cycle; o_s_cyc drops; DRAIN held until m0 drops cyc; a pending m1 request is then granted.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// Two-master pipelined Wishbone arbiter: whole-CYC grants, round-robin on ties, zero added data-path latency.
// Optional watchdog (macro ARB_TIMEOUT_EN) aborts a silent slave via a DRAIN state and a one-cycle err pulse.
module wb_arbiter_2m #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_m0_cyc,
    input  logic                  i_m0_stb,
    input  logic                  i_m0_we,
    input  logic [ADDR_WIDTH-1:0] i_m0_addr,
    input  logic [DATA_WIDTH-1:0] i_m0_data,
    output logic [DATA_WIDTH-1:0] o_m0_data,
    output logic                  o_m0_ack,
    output logic                  o_m0_stall,
    input  logic                  i_m1_cyc,
    input  logic                  i_m1_stb,
    input  logic                  i_m1_we,
    input  logic [ADDR_WIDTH-1:0] i_m1_addr,
    input  logic [DATA_WIDTH-1:0] i_m1_data,
    output logic [DATA_WIDTH-1:0] o_m1_data,
    output logic                  o_m1_ack,
    output logic                  o_m1_stall,
`ifdef ARB_TIMEOUT_EN
    output logic                  o_m0_err,
    output logic                  o_m1_err,
`endif
    output logic                  o_s_cyc,
    output logic                  o_s_stb,
    output logic                  o_s_we,
    output logic [ADDR_WIDTH-1:0] o_s_addr,
    output logic [DATA_WIDTH-1:0] o_s_data,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    input  logic                  i_s_ack,
    input  logic                  i_s_stall,
    output logic [1:0]            o_grant
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_arbiter_2m: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT0  = 2'd1,
        S_GNT1  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   last_owner_q, last_owner_d;
    logic   own1;
    logic   own_cyc;
    logic   other_cyc;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        drain_own1_q;
    logic        err0_q, err1_q;
    logic        in_gnt;
    logic        wd_expire;

    // DRAIN remembers which master it is flushing for
    assign own1 = (state_q == S_GNT1) || ((state_q == S_DRAIN) && drain_own1_q);
`else
    assign own1 = (state_q == S_GNT1);
`endif

    assign own_cyc   = own1 ? i_m1_cyc : i_m0_cyc;
    assign other_cyc = own1 ? i_m0_cyc : i_m1_cyc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            S_IDLE: begin
                if (i_m0_cyc && (!i_m1_cyc || last_owner_q)) begin
                    state_d = S_GNT0;
                end else if (i_m1_cyc) begin
                    state_d = S_GNT1;
                end
            end
            S_GNT0, S_GNT1, S_DRAIN: begin
                // Release hands over directly when the other master is waiting
                if (!own_cyc) begin
                    last_owner_d = own1;
                    state_d      = other_cyc ? (own1 ? S_GNT0 : S_GNT1) : S_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wd_expire) begin
                    state_d = S_DRAIN;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_grant    = 2'b00;
        o_s_cyc    = 1'b0;
        o_s_stb    = 1'b0;
        o_s_we     = 1'b0;
        o_s_addr   = '0;
        o_s_data   = '0;
        o_m0_data  = '0;
        o_m0_ack   = 1'b0;
        o_m0_stall = 1'b1;
        o_m1_data  = '0;
        o_m1_ack   = 1'b0;
        o_m1_stall = 1'b1;
        case (state_q)
            S_GNT0: begin
                o_grant    = 2'b01;
                o_s_cyc    = i_m0_cyc;
                o_s_stb    = i_m0_stb;
                o_s_we     = i_m0_we;
                o_s_addr   = i_m0_addr;
                o_s_data   = i_m0_data;
                o_m0_data  = i_s_data;
                o_m0_ack   = i_s_ack;
                o_m0_stall = i_s_stall;
            end
            S_GNT1: begin
                o_grant    = 2'b10;
                o_s_cyc    = i_m1_cyc;
                o_s_stb    = i_m1_stb;
                o_s_we     = i_m1_we;
                o_s_addr   = i_m1_addr;
                o_s_data   = i_m1_data;
                o_m1_data  = i_s_data;
                o_m1_ack   = i_s_ack;
                o_m1_stall = i_s_stall;
            end
            S_DRAIN: begin
                o_grant = own1 ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    assign in_gnt    = (state_q == S_GNT0) || (state_q == S_GNT1);
    assign wd_expire = in_gnt && own_cyc && !i_s_ack && (wd_cnt_q == WD_LIMIT);

    // Counter is zero outside a live grant, so a fresh grant always starts from zero
    always_comb begin
        wd_cnt_d = 16'd0;
        if (in_gnt && own_cyc && !i_s_ack && !wd_expire) begin
            wd_cnt_d = wd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wd_cnt_q     <= 16'd0;
            drain_own1_q <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
        end else begin
            wd_cnt_q     <= wd_cnt_d;
            drain_own1_q <= own1;
            err0_q       <= wd_expire && !own1;
            err1_q       <= wd_expire && own1;
        end
    end

    assign o_m0_err = err0_q;
    assign o_m1_err = err1_q;
`endif

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: vector table, directed multi-cycle sequences and random traffic
// compared every cycle against an owner/last-owner reference model.
module tb_wb_arbiter_2m;

    localparam int TO = 4;
    localparam int VW = 139;
    typedef logic [VW-1:0] ovec_t;

    logic        clk;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_addr, m0_wdat, m1_addr, m1_wdat;
    logic [31:0] o_m0_data, o_m1_data;
    logic        o_m0_ack, o_m0_stall, o_m1_ack, o_m1_stall;
    logic        m0_err, m1_err;
    logic        o_s_cyc, o_s_stb, o_s_we;
    logic [31:0] o_s_addr, o_s_data;
    logic [31:0] s_data;
    logic        s_ack, s_stall;
    logic [1:0]  o_grant;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who owns the bus, who owned it last, drain/no-ack bookkeeping
    int       m_owner;
    int       m_last;
    int       m_noack;
    bit       m_drain;
    bit [1:0] m_err;

    wb_arbiter_2m #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we),
        .i_m0_addr(m0_addr), .i_m0_data(m0_wdat),
        .o_m0_data(o_m0_data), .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we),
        .i_m1_addr(m1_addr), .i_m1_data(m1_wdat),
        .o_m1_data(o_m1_data), .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall),
`ifdef ARB_TIMEOUT_EN
        .o_m0_err(m0_err), .o_m1_err(m1_err),
`endif
        .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
        .o_s_addr(o_s_addr), .o_s_data(o_s_data),
        .i_s_data(s_data), .i_s_ack(s_ack), .i_s_stall(s_stall),
        .o_grant(o_grant)
    );

`ifndef ARB_TIMEOUT_EN
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input ovec_t act, input ovec_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic ovec_t act_vec();
        return {o_grant, o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data,
                o_m0_data, o_m0_ack, o_m0_stall, o_m1_data, o_m1_ack, o_m1_stall,
                m0_err, m1_err};
    endfunction

    function automatic ovec_t model_out();
        logic [1:0]  g;
        logic        sc, ss, sw, a0, a1, st0, st1;
        logic [31:0] sa, sd, d0, d1;
        g = 2'b00; sc = 0; ss = 0; sw = 0; sa = 0; sd = 0;
        d0 = 0; d1 = 0; a0 = 0; a1 = 0; st0 = 1; st1 = 1;
        if (m_owner == 0) begin
            g = 2'b01;
            if (!m_drain) begin
                sc = m0_cyc; ss = m0_stb; sw = m0_we; sa = m0_addr; sd = m0_wdat;
                d0 = s_data; a0 = s_ack; st0 = s_stall;
            end
        end else if (m_owner == 1) begin
            g = 2'b10;
            if (!m_drain) begin
                sc = m1_cyc; ss = m1_stb; sw = m1_we; sa = m1_addr; sd = m1_wdat;
                d1 = s_data; a1 = s_ack; st1 = s_stall;
            end
        end
        return {g, sc, ss, sw, sa, sd, d0, a0, st0, d1, a1, st1, m_err[0], m_err[1]};
    endfunction

    task automatic model_update();
        bit [1:0] cyc;
        bit [1:0] nerr;
        cyc  = {m1_cyc, m0_cyc};
        nerr = 2'b00;
        if (!rst_n) begin
            m_owner = -1; m_last = 1; m_drain = 0; m_noack = 0;
        end else if (m_owner < 0) begin
            if (cyc == 2'b11) m_owner = 1 - m_last;
            else if (cyc[0]) m_owner = 0;
            else if (cyc[1]) m_owner = 1;
            m_noack = 0;
        end else if (!cyc[m_owner]) begin
            m_last  = m_owner;
            m_drain = 0;
            m_noack = 0;
            m_owner = cyc[1 - m_owner] ? 1 - m_owner : -1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (!m_drain) begin
            if (s_ack) m_noack = 0;
            else if (m_noack == TO - 1) begin
                m_drain = 1;
                nerr[m_owner] = 1'b1;
            end else m_noack++;
        end
`endif
        m_err = nerr;
    endtask

    task automatic step(input string nm);
        #1;
        check(nm, act_vec(), model_out());
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    typedef struct {
        logic       rst_n, c0, c1, ack;
        logic [1:0] g;
        logic       sc, a0, a1;
    } vec_t;

    vec_t tbl[14];

    initial begin
        m_owner = -1; m_last = 1; m_noack = 0; m_drain = 0; m_err = 0;
        rst_n = 0; m0_cyc = 0; m0_stb = 0; m0_we = 1; m1_cyc = 0; m1_stb = 0; m1_we = 1;
        m0_addr = 32'h100; m0_wdat = 32'h1111; m1_addr = 32'h200; m1_wdat = 32'h2222;
        s_data = 32'hD00D; s_ack = 0; s_stall = 0;

        //          rst  c0   c1   ack   grant  s_cyc a0   a1
        tbl[0]  = '{1'b1,1'b1,1'b1,1'b0, 2'b00, 1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b1,1'b1,1'b1, 2'b01, 1'b1,1'b1,1'b0};
        tbl[2]  = '{1'b1,1'b0,1'b1,1'b0, 2'b01, 1'b0,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b0,1'b1,1'b1, 2'b10, 1'b1,1'b0,1'b1};
        tbl[4]  = '{1'b1,1'b0,1'b0,1'b0, 2'b10, 1'b0,1'b0,1'b0};
        tbl[5]  = '{1'b1,1'b1,1'b1,1'b0, 2'b00, 1'b0,1'b0,1'b0};
        tbl[6]  = '{1'b1,1'b1,1'b1,1'b1, 2'b01, 1'b1,1'b1,1'b0};
        tbl[7]  = '{1'b1,1'b0,1'b1,1'b0, 2'b01, 1'b0,1'b0,1'b0};
        tbl[8]  = '{1'b1,1'b0,1'b1,1'b0, 2'b10, 1'b1,1'b0,1'b0};
        tbl[9]  = '{1'b0,1'b0,1'b1,1'b1, 2'b10, 1'b1,1'b0,1'b1};
        tbl[10] = '{1'b1,1'b1,1'b1,1'b1, 2'b00, 1'b0,1'b0,1'b0};
        tbl[11] = '{1'b1,1'b1,1'b0,1'b0, 2'b01, 1'b1,1'b0,1'b0};
        tbl[12] = '{1'b1,1'b0,1'b0,1'b1, 2'b01, 1'b0,1'b1,1'b0};
        tbl[13] = '{1'b1,1'b0,1'b0,1'b1, 2'b00, 1'b0,1'b0,1'b0};

        @(negedge clk);
        adv();
        adv();
        rst_n = 1;
        step("reset_state");

        for (int i = 0; i < 14; i++) begin
            rst_n = tbl[i].rst_n;
            m0_cyc = tbl[i].c0; m0_stb = tbl[i].c0;
            m1_cyc = tbl[i].c1; m1_stb = tbl[i].c1;
            s_ack = tbl[i].ack;
            step("tbl_model");
            check("tbl_grant", ovec_t'(o_grant), ovec_t'(tbl[i].g));
            check("tbl_s_cyc", ovec_t'(o_s_cyc), ovec_t'(tbl[i].sc));
            check("tbl_acks", ovec_t'({o_m0_ack, o_m1_ack}), ovec_t'({tbl[i].a0, tbl[i].a1}));
            adv();
        end

        // m0 alone: slave side mirrors m0, ack goes to m0 only
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 32'h10; m0_wdat = 32'hA5A5;
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        step("m0_req");
        check("m0_req_grant", ovec_t'(o_grant), ovec_t'(2'b00));
        adv();
        s_ack = 1;
        step("m0_xfer");
        check("m0_grant", ovec_t'(o_grant), ovec_t'(2'b01));
        check("m0_mirror", ovec_t'({o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data}),
              ovec_t'({3'b111, 32'h10, 32'hA5A5}));
        check("m0_acks", ovec_t'({o_m0_ack, o_m1_ack}), ovec_t'(2'b10));
        adv();
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        step("m0_release");
        adv();

        // m0 4-beat read burst while m1 waits
        m0_cyc = 1; m0_stb = 1; m0_we = 0;
        step("burst_req");
        adv();
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_addr = 32'h44; m1_wdat = 32'hBEEF;
        for (int b = 0; b < 4; b++) begin
            s_ack = 1; s_data = 32'(b + 1);
            step("burst_beat");
            check("burst_data", ovec_t'(o_m0_data), ovec_t'(b + 1));
            check("burst_m1_blocked", ovec_t'({o_m1_stall, o_m1_ack, o_grant}), ovec_t'(4'b1001));
            adv();
        end
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        step("burst_release");
        check("burst_rel_m1_stall", ovec_t'(o_m1_stall), ovec_t'(1'b1));
        adv();

        // m1 write with three stalled cycles, then one ack
        for (int i = 0; i < 4; i++) begin
            s_stall = (i < 3);
            s_ack   = (i == 3);
            step("stall_cycle");
            check("stall_grant", ovec_t'(o_grant), ovec_t'(2'b10));
            check("stall_m1", ovec_t'({o_m1_stall, o_s_stb, o_m1_ack}),
                  ovec_t'({(i < 3) ? 1'b1 : 1'b0, 1'b1, (i == 3) ? 1'b1 : 1'b0}));
            adv();
        end
        s_stall = 0; s_ack = 0; m1_cyc = 0; m1_stb = 0;
        step("stall_release");
        adv();

`ifdef ARB_TIMEOUT_EN
        // Silent slave on m0 with m1 pending
        m0_cyc = 1; m0_stb = 1; m0_we = 0;
        step("wd_req");
        adv();
        m1_cyc = 1; m1_stb = 1;
        for (int i = 0; i < TO; i++) begin
            step("wd_wait");
            check("wd_no_err", ovec_t'({m0_err, o_grant}), ovec_t'(3'b001));
            adv();
        end
        step("wd_drain");
        check("wd_err_pulse", ovec_t'({m0_err, m1_err, o_s_cyc, o_m0_stall}), ovec_t'(4'b1001));
        adv();
        step("wd_drain2");
        check("wd_err_once", ovec_t'({m0_err, o_s_cyc, o_grant}), ovec_t'(4'b0001));
        adv();
        m0_cyc = 0; m0_stb = 0;
        step("wd_drop");
        adv();
        step("wd_handover");
        check("wd_m1_granted", ovec_t'({o_grant, o_s_cyc}), ovec_t'(3'b101));
        adv();
        m1_cyc = 0; m1_stb = 0;
        step("wd_done");
        adv();
`endif

        for (int n = 0; n < 500; n++) begin
            rst_n = ($urandom_range(49) != 0);
            if ($urandom_range(3) == 0) m0_cyc = ~m0_cyc;
            if ($urandom_range(3) == 0) m1_cyc = ~m1_cyc;
            m0_stb = 1'($urandom_range(1)); m1_stb = 1'($urandom_range(1));
            m0_we = 1'($urandom_range(1));  m1_we = 1'($urandom_range(1));
            m0_addr = $urandom; m1_addr = $urandom; m0_wdat = $urandom; m1_wdat = $urandom;
            s_data = $urandom;
            s_ack = 1'($urandom_range(1));
            s_stall = 1'($urandom_range(1));
            step("random");
            adv();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
